// File: rtl/pkt_sched.sv
`default_nettype none
// ============================================================================
// Module   : pkt_sched
// Purpose  : Packet-granular scheduler from NUM_Q per-priority packet FIFOs
//            onto a single egress stream with backpressure. Drains one whole
//            packet (sop..eop) at a time, drops packets whose head lacks sop,
//            and truncates packets longer than MAX_PKT_LEN words.
// Options  : PKT_SCHED_RR_EN - round-robin arbitration instead of strict
//            priority (index 0 highest).
// Revision : 1.0 - initial release
// ============================================================================
module pkt_sched #(
    parameter int DATA_W      = 16,
    parameter int NUM_Q       = 8,
    parameter int MAX_PKT_LEN = 32,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_Q-1:0]           q_ready,
    input  logic [NUM_Q-1:0]           q_vld,
    input  logic [NUM_Q-1:0]           q_sop,
    input  logic [NUM_Q-1:0]           q_eop,
    input  logic [NUM_Q*DATA_W-1:0]    q_data,
    output logic [NUM_Q-1:0]           q_next_data,
    input  logic                       out_ready,
    output logic                       out_vld,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_Q)-1:0]   out_qid,
    output logic [CNT_W-1:0]           pkt_cnt,
    output logic [CNT_W-1:0]           err_cnt,
    output logic                       err
);

    localparam int                 c_QID_W   = $clog2(NUM_Q);
    localparam int                 c_WC_W    = $clog2(MAX_PKT_LEN + 1);
    localparam logic [1:0]         c_IDLE    = 2'd0;
    localparam logic [1:0]         c_XFER    = 2'd1;
    localparam logic [1:0]         c_FLUSH   = 2'd2;
    localparam logic [c_WC_W-1:0]  c_LAST    = c_WC_W'(MAX_PKT_LEN - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;
    localparam logic [NUM_Q-1:0]   c_ONE     = NUM_Q'(1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_QID_W-1:0]  r_grant;
    logic [c_QID_W-1:0]  w_pick;
    logic [c_WC_W-1:0]   r_wcnt;
    logic                r_out_vld;
    logic                r_out_sop;
    logic                r_out_eop;
    logic [DATA_W-1:0]   r_out_data;
    logic [c_QID_W-1:0]  r_out_qid;
    logic [CNT_W-1:0]    r_pkt_cnt;
    logic [CNT_W-1:0]    r_err_cnt;
    logic                r_err;
    logic [DATA_W-1:0]   w_hd_data;
    logic                w_hd_vld;
    logic                w_hd_sop;
    logic                w_hd_eop;
    logic                w_load;
    logic                w_pop;
    logic                w_start;
    logic                w_fwd;
    logic                w_fwd_eop;
    logic                w_err_evt;
    logic                w_pkt_done;

    assign w_hd_vld = q_vld[r_grant];
    assign w_hd_sop = q_sop[r_grant];
    assign w_hd_eop = q_eop[r_grant];

    // Output register accepts a new word when empty or being consumed.
    assign w_load  = !r_out_vld || out_ready;
    // FLUSH drains regardless of downstream since nothing is forwarded.
    assign w_pop   = !rst && w_hd_vld &&
                     (((r_state == c_XFER) && w_load) || (r_state == c_FLUSH));
    assign w_start = (r_state == c_IDLE) && (|q_ready);

    assign q_next_data = w_pop ? (c_ONE << r_grant) : '0;

    assign out_vld  = r_out_vld;
    assign out_sop  = r_out_sop;
    assign out_eop  = r_out_eop;
    assign out_data = r_out_data;
    assign out_qid  = r_out_qid;
    assign pkt_cnt  = r_pkt_cnt;
    assign err_cnt  = r_err_cnt;
    assign err      = r_err;

    // Select the head word of the granted queue.
    always_comb begin
        w_hd_data = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (r_grant == c_QID_W'(i)) begin
                w_hd_data = q_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef PKT_SCHED_RR_EN
    logic [c_QID_W-1:0] r_rr_ptr;

    // Pick the first ready queue at or after the round-robin pointer.
    always_comb begin
        int idx;
        idx    = 0;
        w_pick = '0;
        for (int k = NUM_Q - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % NUM_Q;
            if (q_ready[idx]) begin
                w_pick = c_QID_W'(idx);
            end
        end
    end

    // Advance the pointer past the queue whose packet just ended or aborted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_pkt_done || w_err_evt) begin
            r_rr_ptr <= (r_grant == c_QID_W'(NUM_Q - 1)) ? '0 : r_grant + c_QID_W'(1);
        end
    end
`else
    // Strict priority: lowest ready index wins.
    always_comb begin
        w_pick = '0;
        for (int i = NUM_Q - 1; i >= 0; i--) begin
            if (q_ready[i]) begin
                w_pick = c_QID_W'(i);
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-word decode of the popped head word.
    always_comb begin
        w_state_nxt = r_state;
        w_fwd       = 1'b0;
        w_fwd_eop   = 1'b0;
        w_err_evt   = 1'b0;
        w_pkt_done  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_XFER;
                end
            end
            c_XFER: begin
                if (w_pop) begin
                    if ((r_wcnt == '0) && !w_hd_sop) begin
                        // A sop-less word that also ends the fragment needs no flush.
                        w_err_evt   = 1'b1;
                        w_state_nxt = w_hd_eop ? c_IDLE : c_FLUSH;
                    end else begin
                        w_fwd     = 1'b1;
                        w_fwd_eop = w_hd_eop;
                        if (w_hd_eop) begin
                            w_pkt_done  = 1'b1;
                            w_state_nxt = c_IDLE;
                        end else if (r_wcnt == c_LAST) begin
                            w_fwd_eop   = 1'b1;
                            w_err_evt   = 1'b1;
                            w_state_nxt = c_FLUSH;
                        end
                    end
                end
            end
            c_FLUSH: begin
                if (w_pop && w_hd_eop) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Grant, word counter, output register, statistics and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= '0;
            r_wcnt     <= '0;
            r_out_vld  <= 1'b0;
            r_out_sop  <= 1'b0;
            r_out_eop  <= 1'b0;
            r_out_data <= '0;
            r_out_qid  <= '0;
            r_pkt_cnt  <= '0;
            r_err_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_err_evt;
            if (w_start) begin
                r_grant <= w_pick;
                r_wcnt  <= '0;
            end else if (w_fwd) begin
                r_wcnt <= r_wcnt + c_WC_W'(1);
            end
            if (w_load) begin
                r_out_vld  <= w_fwd;
                r_out_sop  <= w_fwd && w_hd_sop;
                r_out_eop  <= w_fwd && w_fwd_eop;
                r_out_data <= w_fwd ? w_hd_data : '0;
                r_out_qid  <= w_fwd ? r_grant : '0;
            end
            if (w_pkt_done && (r_pkt_cnt != c_CNT_MAX)) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            end
            if (w_err_evt && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
